// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_fsm
// Purpose  : Moore controller sequencing the lab CPU datapath; optional
//            illegal-opcode trap enabled by defining ILLEGAL_OP_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_fsm #(
   parameter logic [2:0] NSEL_RN = 3'b100,
   parameter logic [2:0] NSEL_RD = 3'b010,
   parameter logic [2:0] NSEL_RM = 3'b001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic       illegal,
`endif
   output logic       w,
   output logic [2:0] nsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic [1:0] vsel,
   output logic       write
);

   localparam logic [4:0] C_MOV_IMM = 5'b110_10;
   localparam logic [4:0] C_MOV_REG = 5'b110_00;
   localparam logic [4:0] C_MVN     = 5'b101_11;
   localparam logic [4:0] C_ADD     = 5'b101_00;
   localparam logic [4:0] C_CMP     = 5'b101_01;
   localparam logic [4:0] C_AND     = 5'b101_10;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_ALU       = 3'd5,
      S_WRITE_REG = 3'd6
`ifdef ILLEGAL_OP_TRAP_EN
      ,
      S_TRAP      = 3'd7
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] opcode_q, opcode_d;
   logic [1:0] op_q, op_d;
   logic [4:0] instr_q;

   assign instr_q = {opcode_q, op_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_WAIT;
         opcode_q <= 3'b000;
         op_q     <= 2'b00;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         op_q     <= op_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      op_d     = op_q;
      w        = 1'b0;
      nsel     = 3'b000;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = 2'b00;
      write    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal  = 1'b0;
`endif
      case (state_q)
         S_WAIT: begin
            w = 1'b1;
            if (s) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Everything after this point works from the latched copy only.
            opcode_d = opcode;
            op_d     = op;
            case ({opcode, op})
               C_MOV_IMM:              state_d = S_WRITE_IMM;
               C_MOV_REG, C_MVN:       state_d = S_GET_B;
               C_ADD, C_CMP, C_AND:    state_d = S_GET_A;
`ifdef ILLEGAL_OP_TRAP_EN
               default:                state_d = S_TRAP;
`else
               default:                state_d = S_WAIT;
`endif
            endcase
         end
         S_WRITE_IMM: begin
            nsel    = NSEL_RN;
            vsel    = 2'b10;
            write   = 1'b1;
            state_d = S_WAIT;
         end
         S_GET_A: begin
            nsel    = NSEL_RN;
            loada   = 1'b1;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            nsel    = NSEL_RM;
            loadb   = 1'b1;
            state_d = S_ALU;
         end
         S_ALU: begin
            asel = (instr_q == C_MOV_REG);
            if (instr_q == C_CMP) begin
               loads   = 1'b1;
               state_d = S_WAIT;
            end else begin
               loadc   = 1'b1;
               state_d = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            nsel    = NSEL_RD;
            vsel    = 2'b00;
            write   = 1'b1;
            state_d = S_WAIT;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP: begin
            illegal = 1'b1;
         end
`endif
         default: begin
            state_d = S_WAIT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_fsm
// Purpose  : Directed self-checking bench for cpu_ctrl_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w, loada, loadb, loadc, loads, asel, bsel, write;
   logic [2:0] nsel;
   logic [1:0] vsel;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegal;
`endif

   int checks = 0;
   int errors = 0;

   cpu_ctrl_fsm dut (
      .clk    (clk),
      .reset  (reset),
      .s      (s),
      .opcode (opcode),
      .op     (op),
`ifdef ILLEGAL_OP_TRAP_EN
      .illegal(illegal),
`endif
      .w      (w),
      .nsel   (nsel),
      .loada  (loada),
      .loadb  (loadb),
      .loadc  (loadc),
      .loads  (loads),
      .asel   (asel),
      .bsel   (bsel),
      .vsel   (vsel),
      .write  (write)
   );

   always #5 clk = ~clk;

   // {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write}
   localparam logic [12:0] O_WAIT    = 13'b1_000_000000_00_0;
   localparam logic [12:0] O_DECODE  = 13'b0_000_000000_00_0;
   localparam logic [12:0] O_WIMM    = 13'b0_100_000000_10_1;
   localparam logic [12:0] O_GETA    = 13'b0_100_100000_00_0;
   localparam logic [12:0] O_GETB    = 13'b0_001_010000_00_0;
   localparam logic [12:0] O_ALU     = 13'b0_000_001000_00_0;
   localparam logic [12:0] O_ALU_MOV = 13'b0_000_001010_00_0;
   localparam logic [12:0] O_ALU_CMP = 13'b0_000_000100_00_0;
   localparam logic [12:0] O_WREG    = 13'b0_010_000000_00_1;

   logic [12:0] outs;
   assign outs = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write};

   task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] oc, input logic [1:0] o);
      opcode = oc;
      op     = o;
      s      = 1'b1;
      step();
      s      = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      s      = 1'b1;
      opcode = 3'b110;
      op     = 2'b10;
      #2;
      check_val("reset_async", outs, O_WAIT);
      step();
      step();
      check_val("reset_hold", outs, O_WAIT);
`ifdef ILLEGAL_OP_TRAP_EN
      check_val("reset_illegal", {12'b0, illegal}, 13'b0);
`endif
      reset = 1'b1;

      // MOV R0,#7 straight out of reset with s held
      step();
      check_val("movi_decode", outs, O_DECODE);
      s = 1'b0;
      step(); check_val("movi_write", outs, O_WIMM);
      step(); check_val("movi_done", outs, O_WAIT);
      step(); check_val("idle_s0", outs, O_WAIT);

      // ADD
      start(3'b101, 2'b00);
      check_val("add_decode", outs, O_DECODE);
      step(); check_val("add_geta", outs, O_GETA);
      step(); check_val("add_getb", outs, O_GETB);
      step(); check_val("add_alu", outs, O_ALU);
      step(); check_val("add_wreg", outs, O_WREG);
      step(); check_val("add_done", outs, O_WAIT);

      // CMP: loads only, no writeback
      start(3'b101, 2'b01);
      check_val("cmp_decode", outs, O_DECODE);
      step(); check_val("cmp_geta", outs, O_GETA);
      step(); check_val("cmp_getb", outs, O_GETB);
      step(); check_val("cmp_alu", outs, O_ALU_CMP);
      step(); check_val("cmp_done", outs, O_WAIT);

      // MOV R2,R1 with opcode corrupted after decode, then back-to-back MOV imm
      start(3'b110, 2'b00);
      check_val("movr_decode", outs, O_DECODE);
      step(); check_val("movr_getb", outs, O_GETB);
      opcode = 3'b000;
      step(); check_val("movr_alu", outs, O_ALU_MOV);
      s = 1'b1;
      step(); check_val("movr_wreg", outs, O_WREG);
      opcode = 3'b110;
      op     = 2'b10;
      step(); check_val("movr_done", outs, O_WAIT);
      step(); check_val("b2b_decode", outs, O_DECODE);
      s = 1'b0;
      step(); check_val("b2b_write", outs, O_WIMM);
      step(); check_val("b2b_done", outs, O_WAIT);

      // MVN
      start(3'b101, 2'b11);
      step(); check_val("mvn_getb", outs, O_GETB);
      step(); check_val("mvn_alu", outs, O_ALU);
      step(); check_val("mvn_wreg", outs, O_WREG);
      step(); check_val("mvn_done", outs, O_WAIT);

      // AND
      start(3'b101, 2'b10);
      step(); check_val("and_geta", outs, O_GETA);
      step(); check_val("and_getb", outs, O_GETB);
      step(); check_val("and_alu", outs, O_ALU);
      step(); check_val("and_wreg", outs, O_WREG);
      step(); check_val("and_done", outs, O_WAIT);

      // Reset during ALU of ADD aborts without writeback
      start(3'b101, 2'b00);
      step(); step(); step();
      check_val("abort_alu", outs, O_ALU);
      #2 reset = 1'b0;
      #1 check_val("abort_async", outs, O_WAIT);
      step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("abort_idle", outs, O_WAIT);
      end

      // Illegal opcode 111/11
      start(3'b111, 2'b11);
      check_val("ill_decode", outs, O_DECODE);
      s = 1'b1;
      step();
`ifdef ILLEGAL_OP_TRAP_EN
      check_val("ill_trap", outs, O_DECODE);
      check_val("ill_flag", {12'b0, illegal}, 13'b1);
      step();
      check_val("ill_hold", outs, O_DECODE);
      check_val("ill_flag_hold", {12'b0, illegal}, 13'b1);
      reset = 1'b0;
      #1;
      check_val("ill_reset", outs, O_WAIT);
      check_val("ill_flag_clr", {12'b0, illegal}, 13'b0);
      s = 1'b0;
      step();
      reset = 1'b1;
`else
      check_val("ill_to_wait", outs, O_WAIT);
      s = 1'b0;
      step();
      check_val("ill_idle", outs, O_WAIT);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
